// File: rtl/atm_pkg.sv
// Shared encodings for the ATM transaction controller: operation selects,
// response status codes, FSM state encoding and default widths.
package atm_pkg;

    localparam int ACCT_W_DEF       = 4;
    localparam int BAL_W_DEF        = 10;
    localparam int INIT_BALANCE_DEF = 100;

    localparam logic [1:0] SEL_DISPLAY  = 2'b00;
    localparam logic [1:0] SEL_DEPOSIT  = 2'b01;
    localparam logic [1:0] SEL_WITHDRAW = 2'b10;
    localparam logic [1:0] SEL_TRANSFER = 2'b11;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_NOFUNDS  = 2'b01;
    localparam logic [1:0] ST_OVERFLOW = 2'b10;
    localparam logic [1:0] ST_INVALID  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

endpackage

// File: rtl/atm_account_store.sv
// Account balance register array with two combinational read ports and two
// write ports; every account resets to INIT_BALANCE.
module atm_account_store
    import atm_pkg::*;
#(
    parameter int ACCT_W       = ACCT_W_DEF,
    parameter int BAL_W        = BAL_W_DEF,
    parameter int INIT_BALANCE = INIT_BALANCE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ACCT_W-1:0] rd_addr_a_i,
    output logic [BAL_W-1:0]  rd_data_a_o,
    input  logic [ACCT_W-1:0] rd_addr_b_i,
    output logic [BAL_W-1:0]  rd_data_b_o,
    input  logic              wr_en_a_i,
    input  logic [ACCT_W-1:0] wr_addr_a_i,
    input  logic [BAL_W-1:0]  wr_data_a_i,
    input  logic              wr_en_b_i,
    input  logic [ACCT_W-1:0] wr_addr_b_i,
    input  logic [BAL_W-1:0]  wr_data_b_i
);

    localparam int NUM_ACCTS = 2 ** ACCT_W;

    logic [BAL_W-1:0] mem_q [NUM_ACCTS];

    assign rd_data_a_o = mem_q[rd_addr_a_i];
    assign rd_data_b_o = mem_q[rd_addr_b_i];

    // The controller never issues both writes to one address, so port A
    // taking precedence is only a tie-break that cannot occur in practice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                mem_q[i] <= BAL_W'(INIT_BALANCE);
            end
        end else begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                if (wr_en_a_i && (wr_addr_a_i == ACCT_W'(i))) begin
                    mem_q[i] <= wr_data_a_i;
                end else if (wr_en_b_i && (wr_addr_b_i == ACCT_W'(i))) begin
                    mem_q[i] <= wr_data_b_i;
                end
            end
        end
    end

endmodule

// File: rtl/atm_transaction_controller.sv
// Sequences one ATM transaction at a time: accept, read both balances,
// check and commit atomically, then hold the response until consumed.
module atm_transaction_controller
    import atm_pkg::*;
#(
    parameter int ACCT_W       = ACCT_W_DEF,
    parameter int BAL_W        = BAL_W_DEF,
    parameter int INIT_BALANCE = INIT_BALANCE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_select,
    input  logic [ACCT_W-1:0] req_origin,
    input  logic [ACCT_W-1:0] req_purpose,
    input  logic [BAL_W-1:0]  req_amount,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [1:0]        resp_status,
    output logic [BAL_W-1:0]  resp_balance,
    output logic [1:0]        dbg_state
);

    // Handshakes: a request transfers on a rising edge with req_valid &&
    // req_ready (only in IDLE); a response transfers on a rising edge with
    // resp_valid && resp_ready, and resp_* stay stable until then.

    logic [1:0]        state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [ACCT_W-1:0] origin_q, origin_d;
    logic [ACCT_W-1:0] purpose_q, purpose_d;
    logic [BAL_W-1:0]  amount_q, amount_d;
    logic [BAL_W-1:0]  orig_bal_q, orig_bal_d;
    logic [BAL_W-1:0]  dest_bal_q, dest_bal_d;
    logic [1:0]        resp_status_q, resp_status_d;
    logic [BAL_W-1:0]  resp_balance_q, resp_balance_d;

    logic [BAL_W-1:0]  rd_data_a;
    logic [BAL_W-1:0]  rd_data_b;
    logic [BAL_W:0]    sum_orig;
    logic [BAL_W:0]    diff_orig;
    logic [BAL_W:0]    sum_dest;
    logic [1:0]        exec_status;
    logic [BAL_W-1:0]  exec_balance;
    logic              exec_wr_a;
    logic              exec_wr_b;
    logic              wr_en_a;
    logic              wr_en_b;
    logic [BAL_W-1:0]  wr_data_a;
    logic [BAL_W-1:0]  wr_data_b;

    assign req_ready    = (state_q == S_IDLE);
    assign resp_valid   = (state_q == S_RESP);
    assign resp_status  = resp_status_q;
    assign resp_balance = resp_balance_q;
    assign dbg_state    = state_q;

    // Extra carry/borrow bit flags overflow and insufficient funds directly.
    assign sum_orig  = {1'b0, orig_bal_q} + {1'b0, amount_q};
    assign diff_orig = {1'b0, orig_bal_q} - {1'b0, amount_q};
    assign sum_dest  = {1'b0, dest_bal_q} + {1'b0, amount_q};

    always_comb begin
        exec_status  = ST_OK;
        exec_balance = orig_bal_q;
        exec_wr_a    = 1'b0;
        exec_wr_b    = 1'b0;
        case (sel_q)
            SEL_DEPOSIT: begin
                if (sum_orig[BAL_W]) begin
                    exec_status = ST_OVERFLOW;
                end else begin
                    exec_wr_a    = 1'b1;
                    exec_balance = sum_orig[BAL_W-1:0];
                end
            end
            SEL_WITHDRAW: begin
                if (diff_orig[BAL_W]) begin
                    exec_status = ST_NOFUNDS;
                end else begin
                    exec_wr_a    = 1'b1;
                    exec_balance = diff_orig[BAL_W-1:0];
                end
            end
            SEL_TRANSFER: begin
                if (origin_q == purpose_q) begin
                    exec_status = ST_INVALID;
                end else if (diff_orig[BAL_W]) begin
                    exec_status = ST_NOFUNDS;
                end else if (sum_dest[BAL_W]) begin
                    exec_status = ST_OVERFLOW;
                end else begin
                    exec_wr_a    = 1'b1;
                    exec_wr_b    = 1'b1;
                    exec_balance = diff_orig[BAL_W-1:0];
                end
            end
            default: begin
                exec_status = ST_OK;
            end
        endcase
    end

    assign wr_en_a   = (state_q == S_EXEC) && exec_wr_a;
    assign wr_en_b   = (state_q == S_EXEC) && exec_wr_b;
    assign wr_data_a = (sel_q == SEL_DEPOSIT) ? sum_orig[BAL_W-1:0] : diff_orig[BAL_W-1:0];
    assign wr_data_b = sum_dest[BAL_W-1:0];

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        origin_d       = origin_q;
        purpose_d      = purpose_q;
        amount_d       = amount_q;
        orig_bal_d     = orig_bal_q;
        dest_bal_d     = dest_bal_q;
        resp_status_d  = resp_status_q;
        resp_balance_d = resp_balance_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    sel_d     = req_select;
                    origin_d  = req_origin;
                    purpose_d = req_purpose;
                    amount_d  = req_amount;
                    state_d   = S_READ;
                end
            end
            S_READ: begin
                orig_bal_d = rd_data_a;
                dest_bal_d = rd_data_b;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                resp_status_d  = exec_status;
                resp_balance_d = exec_balance;
                state_d        = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            sel_q          <= SEL_DISPLAY;
            origin_q       <= '0;
            purpose_q      <= '0;
            amount_q       <= '0;
            orig_bal_q     <= '0;
            dest_bal_q     <= '0;
            resp_status_q  <= ST_OK;
            resp_balance_q <= '0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            origin_q       <= origin_d;
            purpose_q      <= purpose_d;
            amount_q       <= amount_d;
            orig_bal_q     <= orig_bal_d;
            dest_bal_q     <= dest_bal_d;
            resp_status_q  <= resp_status_d;
            resp_balance_q <= resp_balance_d;
        end
    end

    atm_account_store #(
        .ACCT_W      (ACCT_W),
        .BAL_W       (BAL_W),
        .INIT_BALANCE(INIT_BALANCE)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .rd_addr_a_i(origin_q),
        .rd_data_a_o(rd_data_a),
        .rd_addr_b_i(purpose_q),
        .rd_data_b_o(rd_data_b),
        .wr_en_a_i  (wr_en_a),
        .wr_addr_a_i(origin_q),
        .wr_data_a_i(wr_data_a),
        .wr_en_b_i  (wr_en_b),
        .wr_addr_b_i(purpose_q),
        .wr_data_b_i(wr_data_b)
    );

endmodule
